frame_buffer_arbiter: RTL and testbench

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

---
 rtl/frame_buffer_arbiter.sv | 172 +++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// Frame buffer arbiter: a clear engine fills the whole buffer with one
// colour, and raster writes and transfer reads share the single memory port
// through a round-robin arbiter while no clear is running.
//
// Handshake: a requester holds req (with its address/data stable) until it
// sees its gnt high in the same cycle. The grant is combinational and the
// request is considered accepted in that cycle. The memory access follows on
// the fb_* port one cycle later. Read data returns on xfer_rdata with
// xfer_rvalid two cycles after the grant.

`ifndef FRAME_BUFFER_ADDR_SIZE
`define FRAME_BUFFER_ADDR_SIZE 4
`endif
`ifndef WIDTH
`define WIDTH 4
`endif
`ifndef HEIGHT
`define HEIGHT 4
`endif

module frame_buffer_arbiter #(
    parameter int ADDR_W     = `FRAME_BUFFER_ADDR_SIZE,
    parameter int NUM_PIXELS = `WIDTH*`HEIGHT
) (
    input  logic              clk,
    input  logic              n_rst,
    // clear request port
    input  logic              clear_req,
    input  logic [23:0]       clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    // raster write port
    input  logic              raster_req,
    input  logic [ADDR_W-1:0] raster_addr,
    input  logic [23:0]       raster_color,
    output logic              raster_gnt,
    // transfer read port
    input  logic              xfer_req,
    input  logic [ADDR_W-1:0] xfer_addr,
    output logic              xfer_gnt,
    output logic [31:0]       xfer_rdata,
    output logic              xfer_rvalid,
    // frame buffer memory port
    output logic [ADDR_W-1:0] fb_addr,
    output logic [23:0]       fb_wdata,
    output logic              fb_we,
    output logic              fb_re,
    input  logic [23:0]       fb_rdata,
    // FSM state for debug / checkers
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [23:0]       color_q, color_d;
    // 1 when the transfer port won the most recent arbitration
    logic              last_xfer_q, last_xfer_d;

    logic              fb_we_q, fb_we_d;
    logic              fb_re_q, fb_re_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [23:0]       fb_wdata_q, fb_wdata_d;
    logic              rvalid_q;

    logic              raster_gnt_c, xfer_gnt_c;

    // Next-state, arbitration and next memory-port command
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        color_d      = color_q;
        last_xfer_d  = last_xfer_q;
        raster_gnt_c = 1'b0;
        xfer_gnt_c   = 1'b0;
        fb_we_d      = 1'b0;
        fb_re_d      = 1'b0;
        fb_addr_d    = '0;
        fb_wdata_d   = '0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    // A clear request takes the cycle; nobody is granted.
                    state_d = CLEAR;
                    cnt_d   = '0;
                    color_d = clear_color;
                end else if (raster_req && (!xfer_req || last_xfer_q)) begin
                    raster_gnt_c = 1'b1;
                    last_xfer_d  = 1'b0;
                    fb_we_d      = 1'b1;
                    fb_addr_d    = raster_addr;
                    fb_wdata_d   = raster_color;
                end else if (xfer_req) begin
                    xfer_gnt_c  = 1'b1;
                    last_xfer_d = 1'b1;
                    fb_re_d     = 1'b1;
                    fb_addr_d   = xfer_addr;
                end
            end
            CLEAR: begin
                // One fill write per cycle; the counter stops on the last word.
                fb_we_d    = 1'b1;
                fb_addr_d  = cnt_q;
                fb_wdata_d = color_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, clear counter, latched colour and round-robin pointer
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            color_q     <= '0;
            last_xfer_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            color_q     <= color_d;
            last_xfer_q <= last_xfer_d;
        end
    end

    // Registered memory command, and read-return tracking one cycle behind it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fb_we_q    <= 1'b0;
            fb_re_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            fb_we_q    <= fb_we_d;
            fb_re_q    <= fb_re_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
            rvalid_q   <= fb_re_q;
        end
    end

    // Grants are gated by reset so every output is low while n_rst is low.
    assign raster_gnt  = n_rst & raster_gnt_c;
    assign xfer_gnt    = n_rst & xfer_gnt_c;
    assign clear_busy  = (state_q == CLEAR) || (state_q == DONE);
    assign clear_done  = (state_q == DONE);
    assign fb_we       = fb_we_q;
    assign fb_re       = fb_re_q;
    assign fb_addr     = fb_addr_q;
    assign fb_wdata    = fb_wdata_q;
    assign xfer_rvalid = rvalid_q;
    assign xfer_rdata  = rvalid_q ? {8'h00, fb_rdata} : 32'h0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Testbench for frame_buffer_arbiter: directed scenarios plus randomized
// request traffic, with a transaction-level reference model feeding
// expected-transaction queues that an independent monitor drains.

module tb_frame_buffer_arbiter;

    localparam int AW   = 4;
    localparam int NP   = 16;
    localparam int WR_W = 32 + AW + 24;   // {cycle, addr, data}
    localparam int RD_W = 32 + AW;        // {cycle, addr}
    localparam int RQ_W = 64;             // {cycle, rdata}

    logic          clk;
    logic          n_rst;
    logic          clear_req;
    logic [23:0]   clear_color;
    logic          clear_busy;
    logic          clear_done;
    logic          raster_req;
    logic [AW-1:0] raster_addr;
    logic [23:0]   raster_color;
    logic          raster_gnt;
    logic          xfer_req;
    logic [AW-1:0] xfer_addr;
    logic          xfer_gnt;
    logic [31:0]   xfer_rdata;
    logic          xfer_rvalid;
    logic [AW-1:0] fb_addr;
    logic [23:0]   fb_wdata;
    logic          fb_we;
    logic          fb_re;
    logic [23:0]   fb_rdata;
    logic [1:0]    dbg_state;

    logic [WR_W-1:0] wr_exp_q[$];
    logic [RD_W-1:0] rd_exp_q[$];
    logic [RQ_W-1:0] rdat_exp_q[$];

    logic [23:0] mem     [NP];
    logic [23:0] ref_mem [NP];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;

    frame_buffer_arbiter #(.ADDR_W(AW), .NUM_PIXELS(NP)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .raster_req   (raster_req),
        .raster_addr  (raster_addr),
        .raster_color (raster_color),
        .raster_gnt   (raster_gnt),
        .xfer_req     (xfer_req),
        .xfer_addr    (xfer_addr),
        .xfer_gnt     (xfer_gnt),
        .xfer_rdata   (xfer_rdata),
        .xfer_rvalid  (xfer_rvalid),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .fb_we        (fb_we),
        .fb_re        (fb_re),
        .fb_rdata     (fb_rdata),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    function automatic logic [23:0] init_word(input int i);
        return (i == 3) ? 24'h00AB12 : 24'((i + 1) * 32'h0002_4F1D);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fb_port"}, 64'({fb_addr, fb_wdata, fb_we, fb_re}), 64'd0);
        chk({tag, "_ctl"}, 64'({xfer_rdata, xfer_rvalid, raster_gnt, xfer_gnt,
                                clear_busy, clear_done, dbg_state}), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- frame buffer memory (synchronous read) ----------------
    initial begin : fb_memory
        for (int i = 0; i < NP; i++) mem[i] = init_word(i);
        fb_rdata <= 24'h0;
        forever begin
            @(posedge clk);
            if (fb_we) mem[fb_addr] = fb_wdata;
            if (fb_re) fb_rdata <= mem[fb_addr];
        end
    end

    // ---------------- reference model ----------------
    // Transaction view: in an idle cycle a clear request schedules all NP
    // fill writes and NP+1 busy cycles; otherwise the requester that did not
    // win last time wins a conflict. Writes appear one cycle after the grant,
    // read data two cycles after, taken from the model memory at grant time.
    initial begin : ref_model
        int   busy_left;
        logic last_x;
        logic eg_r;
        logic eg_x;
        busy_left = 0;
        last_x    = 1'b1;
        for (int i = 0; i < NP; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                busy_left = 0;
                last_x    = 1'b1;
            end else begin
                eg_r = 1'b0;
                eg_x = 1'b0;
                if (busy_left > 0) begin
                    chk("clear_busy", 64'(clear_busy), 64'd1);
                    chk("clear_done", 64'(clear_done), 64'(busy_left == 1));
                    busy_left--;
                end else begin
                    chk("clear_busy", 64'(clear_busy), 64'd0);
                    chk("clear_done", 64'(clear_done), 64'd0);
                    if (clear_req) begin
                        for (int i = 0; i < NP; i++) begin
                            wr_exp_q.push_back({32'(cyc + 2 + i), AW'(i), clear_color});
                            ref_mem[i] = clear_color;
                        end
                        busy_left = NP + 1;
                    end else if (raster_req && (!xfer_req || last_x)) begin
                        eg_r   = 1'b1;
                        last_x = 1'b0;
                        wr_exp_q.push_back({32'(cyc + 1), raster_addr, raster_color});
                        ref_mem[raster_addr] = raster_color;
                    end else if (xfer_req) begin
                        eg_x   = 1'b1;
                        last_x = 1'b1;
                        rd_exp_q.push_back({32'(cyc + 1), xfer_addr});
                        rdat_exp_q.push_back({32'(cyc + 2), 8'h00, ref_mem[xfer_addr]});
                    end
                end
                chk("raster_gnt", 64'(raster_gnt), 64'(eg_r));
                chk("xfer_gnt", 64'(xfer_gnt), 64'(eg_x));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic [WR_W-1:0] we;
        logic [RD_W-1:0] re;
        logic [RQ_W-1:0] de;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                check_zero("in_reset");
            end else begin
                chk("we_re_exclusive", 64'(fb_we & fb_re), 64'd0);
                // expected transactions whose cycle has passed were never seen
                while (wr_exp_q.size() > 0) begin
                    we = wr_exp_q[0];
                    if (int'(we[WR_W-1 -: 32]) >= cyc) break;
                    void'(wr_exp_q.pop_front());
                    chk("write_missing", 64'(cyc), 64'(we[WR_W-1 -: 32]));
                end
                while (rd_exp_q.size() > 0) begin
                    re = rd_exp_q[0];
                    if (int'(re[RD_W-1 -: 32]) >= cyc) break;
                    void'(rd_exp_q.pop_front());
                    chk("read_missing", 64'(cyc), 64'(re[RD_W-1 -: 32]));
                end
                while (rdat_exp_q.size() > 0) begin
                    de = rdat_exp_q[0];
                    if (int'(de[RQ_W-1 -: 32]) >= cyc) break;
                    void'(rdat_exp_q.pop_front());
                    chk("rvalid_missing", 64'(cyc), 64'(de[RQ_W-1 -: 32]));
                end
                if (fb_we) begin
                    if (wr_exp_q.size() == 0) chk("write_unexpected", 64'(fb_we), 64'd0);
                    else begin
                        we = wr_exp_q.pop_front();
                        chk("write_cycle", 64'(cyc), 64'(we[WR_W-1 -: 32]));
                        chk("write_addr", 64'(fb_addr), 64'(we[24 +: AW]));
                        chk("write_data", 64'(fb_wdata), 64'(we[23:0]));
                    end
                end
                if (fb_re) begin
                    if (rd_exp_q.size() == 0) chk("read_unexpected", 64'(fb_re), 64'd0);
                    else begin
                        re = rd_exp_q.pop_front();
                        chk("read_cycle", 64'(cyc), 64'(re[RD_W-1 -: 32]));
                        chk("read_addr", 64'(fb_addr), 64'(re[AW-1:0]));
                    end
                end
                if (xfer_rvalid) begin
                    if (rdat_exp_q.size() == 0) chk("rvalid_unexpected", 64'(xfer_rvalid), 64'd0);
                    else begin
                        de = rdat_exp_q.pop_front();
                        chk("rdata_cycle", 64'(cyc), 64'(de[RQ_W-1 -: 32]));
                        chk("rdata_value", 64'(xfer_rdata), 64'(de[31:0]));
                    end
                end else begin
                    chk("rdata_idle_zero", 64'(xfer_rdata), 64'd0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_raster_gnt(input int max_cyc, input string tag);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            @(negedge clk);
            got = raster_gnt;
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(got), 64'd1);
    endtask

    task automatic random_phase(input int n, input int clr_pct);
        logic rg;
        logic xg;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rg = raster_gnt;
            xg = xfer_gnt;
            @(posedge clk);
            #1;
            if (!raster_req || rg) begin
                raster_req   = ($urandom_range(0, 99) < 55);
                raster_addr  = AW'($urandom);
                raster_color = 24'($urandom);
            end
            if (!xfer_req || xg) begin
                xfer_req  = ($urandom_range(0, 99) < 55);
                xfer_addr = AW'($urandom);
            end
            clear_req   = ($urandom_range(0, 99) < clr_pct);
            clear_color = 24'($urandom);
        end
        raster_req = 1'b0;
        xfer_req   = 1'b0;
        clear_req  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        logic found;
        n_rst        = 1'b0;
        clear_req    = 1'b0;
        clear_color  = 24'h0;
        raster_req   = 1'b0;
        raster_addr  = '0;
        raster_color = 24'h0;
        xfer_req     = 1'b0;
        xfer_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");

        // both requesters held from reset: raster, xfer, raster, xfer
        n_rst        = 1'b1;
        raster_req   = 1'b1;
        raster_addr  = AW'(1);
        raster_color = 24'h111111;
        xfer_req     = 1'b1;
        xfer_addr    = AW'(2);
        repeat (4) step();
        raster_req = 1'b0;
        xfer_req   = 1'b0;
        step();

        // lone raster write to address 5
        raster_req   = 1'b1;
        raster_addr  = AW'(5);
        raster_color = 24'hFF0000;
        step();
        raster_req = 1'b0;

        // lone transfer read of address 3
        xfer_req  = 1'b1;
        xfer_addr = AW'(3);
        step();
        xfer_req = 1'b0;
        repeat (3) step();

        // clear together with a raster request that is held until granted
        clear_req    = 1'b1;
        clear_color  = 24'h102030;
        raster_req   = 1'b1;
        raster_addr  = AW'(9);
        raster_color = 24'hABCDEF;
        step();
        clear_req   = 1'b0;
        clear_color = 24'h777777;
        wait_raster_gnt(40, "raster_after_clear");
        raster_req = 1'b0;
        repeat (3) step();

        random_phase(1500, 3);
        repeat (25) step();

        // reset in the middle of a clear, at fill address 7
        clear_req   = 1'b1;
        clear_color = 24'h5A5A5A;
        step();
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = fb_we && (fb_addr == AW'(7)) && clear_busy;
        end
        chk("abort_reach_addr7", 64'(found), 64'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check_zero("abort");
        wr_exp_q.delete();
        rd_exp_q.delete();
        rdat_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;

        // a new clear restarts from address 0 and rewrites every word
        clear_req   = 1'b1;
        clear_color = 24'h0F0F0F;
        step();
        clear_req = 1'b0;
        repeat (20) step();

        random_phase(400, 2);
        repeat (25) step();

        chk("drain_writes", 64'(wr_exp_q.size()), 64'd0);
        chk("drain_reads", 64'(rd_exp_q.size()), 64'd0);
        chk("drain_rdata", 64'(rdat_exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
